// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with sequenced clear
//
// Purpose: decode-stage register file with two write ports and NUM_READ combinational
// read ports. Optional hardwired-zero register 0 and optional same-cycle write-to-read
// forwarding. After reset the array is cleared one entry per cycle while busy is high.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (starts the clear sequence)
//   rd_addr  packed read addresses, port k at [k*AW +: AW]
//   rd_data  packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   we0/wa0/wd0, we1/wa1/wd1  write ports; port 1 wins on equal addresses
//   busy     high while the clear sequence runs (reads forced to 0, writes dropped)
//   wr_drop  one-cycle pulse: a write enable was seen and discarded while busy
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_READ*$clog2(NUM_REGS)-1:0]      rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]            rd_data,
  input  logic                                      we0,
  input  logic [$clog2(NUM_REGS)-1:0]               wa0,
  input  logic [DATA_WIDTH-1:0]                     wd0,
  input  logic                                      we1,
  input  logic [$clog2(NUM_REGS)-1:0]               wa1,
  input  logic [DATA_WIDTH-1:0]                     wd1,
  output logic                                      busy,
  output logic                                      wr_drop
);

  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           clr_idx_q, clr_idx_d;
  logic                    busy_q, busy_d;
  logic                    wr_drop_q, wr_drop_d;
  logic [DATA_WIDTH-1:0]   mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   mem_d [NUM_REGS];

  logic                    wr0_en, wr1_en;
  logic [AW-1:0]           rd_a;
  logic [DATA_WIDTH-1:0]   rd_v;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data_c;

  // Effective write enables: only in READY, not on a reset edge, and never to the
  // hardwired-zero entry. Shared by the array update and the bypass path so a value
  // is only forwarded if it will actually be written.
  always_comb begin
    wr0_en = (state_q == READY) && !rst && we0 && !((ZERO_REG != 0) && (wa0 == '0));
    wr1_en = (state_q == READY) && !rst && we1 && !((ZERO_REG != 0) && (wa1 == '0));
  end

  // Next-state, clear sequencing and array update.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wr_drop_d = 1'b0;
    mem_d     = mem_q;
    if (state_q == CLEAR) begin
      mem_d[clr_idx_q] = '0;
      clr_idx_d        = clr_idx_q + AW'(1);
      wr_drop_d        = we0 | we1;
      if (clr_idx_q == AW'(NUM_REGS - 1)) begin
        state_d = READY;
      end
    end else begin
      // Port 1 is applied last so it wins when both target the same entry.
      if (wr0_en) mem_d[wa0] = wd0;
      if (wr1_en) mem_d[wa1] = wd1;
    end
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
    end
    // The array holds its contents through reset; the clear sequence zeroes it.
    mem_q <= mem_d;
  end

  // Combinational read ports with optional forwarding (port 1 priority).
  always_comb begin
    rd_data_c = '0;
    rd_a      = '0;
    rd_v      = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rd_a = rd_addr[k*AW +: AW];
      rd_v = mem_q[rd_a];
      if (BYPASS != 0) begin
        if (wr0_en && (wa0 == rd_a)) rd_v = wd0;
        if (wr1_en && (wa1 == rd_a)) rd_v = wd1;
      end
      if (busy_q || ((ZERO_REG != 0) && (rd_a == '0))) begin
        rd_v = '0;
      end
      rd_data_c[k*DATA_WIDTH +: DATA_WIDTH] = rd_v;
    end
  end

  assign rd_data = rd_data_c;
  assign busy    = busy_q;
  assign wr_drop = wr_drop_q;

endmodule
